// File: rtl/mux_nx1_scan_if.sv
// Bus bundle for mux_nx1_scan: packed channel inputs and control, registered outputs.
// The slave side is the mux; the master side is whoever drives the channels.
interface mux_nx1_scan_if #(
  parameter int CH   = 8,
  parameter int W    = 1,
  parameter int SELW = $clog2(CH)
);
  logic [CH*W-1:0] in;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            en;
  logic [W-1:0]    out;
  logic [SELW-1:0] out_ch;
  logic            out_valid;
  logic            wrap;

  modport master (
    output in, sel, mode, en,
    input  out, out_ch, out_valid, wrap
  );

  modport slave (
    input  in, sel, mode, en,
    output out, out_ch, out_valid, wrap
  );
endinterface

// File: rtl/mux_nx1_scan.sv
// N:1 registered mux with manual select and a self-timed channel scanner.
// Output registers load from the next-pointer value so each channel shows for exactly DWELL cycles.
module mux_nx1_scan #(
  parameter int CH    = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  mux_nx1_scan_if.slave    bus
);
  localparam int              DW    = $clog2(DWELL + 1);
  localparam logic [SELW-1:0] LAST  = SELW'(CH - 1);
  localparam logic [DW-1:0]   DLAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t                  state, state_nxt;
  logic [SELW-1:0]         ptr, ptr_nxt;
  logic [DW-1:0]           dcnt, dcnt_nxt;
  logic                    wrap_nxt;
  logic                    sel_ok;
  logic [SELW-1:0]         rd_idx;
  logic [W-1:0]            rd_data;
  logic                    rd_hit;
  logic [CH-1:0][W-1:0]    ch_data;

  assign ch_data = bus.in;
  assign sel_ok  = int'(bus.sel) < CH;

  // Next state, scan pointer and dwell counter. A mode change always wins over a dwell expiry.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    dcnt_nxt  = dcnt;
    wrap_nxt  = 1'b0;
    if (bus.en) begin
      if (bus.mode) begin
        state_nxt = SCAN;
        if (state != SCAN) begin
          ptr_nxt  = sel_ok ? bus.sel : '0;
          dcnt_nxt = '0;
        end else if (dcnt == DLAST) begin
          dcnt_nxt = '0;
          if (ptr == LAST) begin
            ptr_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end else begin
        state_nxt = MANUAL;
      end
    end
  end

  assign rd_idx = bus.mode ? ptr_nxt : bus.sel;

  // Decoded read: an index past CH-1 matches nothing, giving zero data and no hit.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (rd_idx == SELW'(k)) begin
        rd_data = ch_data[k];
        rd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      dcnt          <= '0;
      bus.wrap      <= 1'b0;
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      dcnt     <= dcnt_nxt;
      bus.wrap <= wrap_nxt;
      if (bus.en) begin
        bus.out       <= rd_data;
        bus.out_ch    <= rd_idx;
        bus.out_valid <= rd_hit;
      end
    end
  end
endmodule
